bin_to_gray_counter: RTL and testbench
======================================

Name: bin_to_gray_counter

Overview:
- Up/down binary counter with a registered Gray-coded output. It is the encoder side of the team's Gray-code path.
- Produces Gray pointers or sequences that are later decoded downstream. Typical uses are async-FIFO pointers and Gray-sequenced stimulus.
- Supports load of a Gray-coded value, which is decoded internally to binary. Supports wrap or saturate at the range limits.
- Binary and Gray state are both held in flops, so consumers never see combinational Gray glitches.

Parameters:
- N, 4, counter/code width in bits (N >= 2)
- SATURATE, 0, 0 = wrap modulo 2^N; 1 = hold at limit (2^N-1 counting up, 0 counting down)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  count-step request for this cycle
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only with en
- ld  input  1  load request
- ld_gray  input  N  Gray-coded load value, sampled when ld=1
- bin  output  N  registered binary count
- gray  output  N  registered Gray code of bin
- wrap  output  1  one-cycle pulse: the last update wrapped
- at_max  output  1  registered; bin == 2^N-1
- at_min  output  1  registered; bin == 0

Behaviour:
- Reset (async assert, deassert synchronous to clk):
  - bin=0, gray=0, wrap=0, at_max=0, at_min=1.
  - Reset asserted mid-count clears immediately, without waiting for clk.
- Per rising edge, priority is rst > ld > en > hold.
- Load:
  - nb = Gray-to-binary of ld_gray: nb[N-1]=ld_gray[N-1], nb[i]=ld_gray[i]^nb[i+1].
  - bin<=nb; gray<=ld_gray (equal to nb^(nb>>1)).
  - wrap<=0. en and up are ignored that cycle.
- Step, up=1:
  - nb = bin+1, truncated to N bits.
  - If bin==2^N-1 and SATURATE=0: nb=0 and wrap<=1.
  - If bin==2^N-1 and SATURATE=1: nb=bin and wrap<=0.
- Step, up=0:
  - nb = bin-1.
  - If bin==0 and SATURATE=0: nb=2^N-1 and wrap<=1.
  - If bin==0 and SATURATE=1: nb=0 and wrap<=0.
- Hold (en=0, ld=0): bin and gray unchanged; wrap<=0.
- gray is always registered from nb^(nb>>1) in the same edge as bin, so bin and gray are never one cycle apart.
- at_max and at_min are registered from nb. They are never both 1 (N>=2).
- Latency: inputs sampled at edge k appear on all outputs after edge k. Throughput is one step per cycle.
- A direction change while en is held takes effect at the very next edge; no dead cycle.
- Consecutive en steps change gray in exactly one bit, including across the wrap. Load may change any number of bits.

Optional Feature:
- Macro GRAY_STEP_CHECK_EN.
- Defined:
  - Adds output step_err (1 bit), reset 0, sticky until rst.
  - Set on the edge after an en step (ld=0) in which the registered gray changed in a number of bits other than exactly 1.
  - A saturated hold (0 bits changed) is exempt.
  - Load cycles are excluded from the check.
  - The comparison uses a registered copy of the previous gray.
- Undefined: port and logic absent; functional behaviour otherwise identical.

Test Plan:
- Reset, then en=1, up=1 for 16 cycles (N=4):
  - gray follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000 with bin 1111->0000.
  - wrap pulses exactly once, on the 0000 edge.
  - at_max=1 while bin=1111.
- From reset, en=1, up=0 for one cycle -> bin=1111, gray=1000, wrap=1 for one cycle, at_max=1, at_min=0.
- ld=1, ld_gray=0110 -> bin=0100, gray=0110, wrap=0. Then ld=1, en=1, up=1 with ld_gray=1000 -> bin=1111 (load wins, no step).
- SATURATE=1: count up to 1111, hold en=1 and up=1 for 3 more cycles -> bin stays 1111, gray stays 1000, wrap never 1. Then up=0 for 1 cycle -> bin=1110, gray=1001.
- Count to bin=0101, assert rst between clock edges -> bin, gray and wrap go to 0 and at_min=1 before the next edge. Deassert rst with en=1, up=1 -> bin=0001 after the first edge.
- With GRAY_STEP_CHECK_EN: a full up sweep, a down sweep and random loads give step_err=0. Forcing gray to flip 2 bits on an en step sets step_err=1, which stays 1 until rst.

Source files
------------

// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with a registered Gray-coded output and Gray-coded load.
// Optional step-integrity monitor (output step_err) is built when GRAY_STEP_CHECK_EN is defined.
module bin_to_gray_counter #(
    parameter int unsigned N        = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         ld,
    input  logic [N-1:0] ld_gray,
    output logic [N-1:0] bin,
    output logic [N-1:0] gray,
    output logic         wrap,
    output logic         at_max,
    output logic         at_min
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic         step_err
`endif
);

    logic [N-1:0] ld_bin;
    logic [N-1:0] nb;
    logic [N-1:0] ngray;
    logic         nwrap;

    always_comb begin
        ld_bin        = '0;
        ld_bin[N-1]   = ld_gray[N-1];
        for (int unsigned i = N - 1; i > 0; i--) begin
            ld_bin[i-1] = ld_gray[i-1] ^ ld_bin[i];
        end
    end

    always_comb begin
        nb    = bin;
        nwrap = 1'b0;
        if (ld) begin
            nb = ld_bin;
        end else if (en) begin
            if (up) begin
                if (bin == '1) begin
                    if (!SATURATE) begin
                        nb    = '0;
                        nwrap = 1'b1;
                    end
                end else begin
                    nb = bin + 1'b1;
                end
            end else begin
                if (bin == '0) begin
                    if (!SATURATE) begin
                        nb    = '1;
                        nwrap = 1'b1;
                    end
                end else begin
                    nb = bin - 1'b1;
                end
            end
        end
    end

    // Load takes the supplied code verbatim; it equals the encoding of ld_bin.
    assign ngray = ld ? ld_gray : (nb ^ (nb >> 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin    <= '0;
            gray   <= '0;
            wrap   <= 1'b0;
            at_max <= 1'b0;
            at_min <= 1'b1;
        end else begin
            bin    <= nb;
            gray   <= ngray;
            wrap   <= nwrap;
            at_max <= (nb == '1);
            at_min <= (nb == '0);
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [N-1:0] gray_prev;
    logic         step_pend;
    logic         sat_pend;
    int unsigned  flips;

    always_comb begin
        flips = 0;
        for (int unsigned i = 0; i < N; i++) begin
            flips = flips + {31'd0, gray[i] ^ gray_prev[i]};
        end
    end

    // Judges the previous edge's step: exactly one flip, or none when it was a saturated hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_prev <= '0;
            step_pend <= 1'b0;
            sat_pend  <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            gray_prev <= gray;
            step_pend <= en && !ld;
            sat_pend  <= en && !ld && (nb == bin);
            if (step_pend && !((flips == 1) || (flips == 0 && sat_pend))) begin
                step_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Self-checking bench: wrapping and saturating instances share stimulus and are
// compared each cycle against an arithmetic reference model.
module tb_bin_to_gray_counter;

    localparam int N    = 4;
    localparam int MAXV = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst, en, up, ld;
    logic [N-1:0] ld_gray;
    logic [N-1:0] bin0, gray0, bin1, gray1;
    logic         wrap0, at_max0, at_min0, wrap1, at_max1, at_min1;
`ifdef GRAY_STEP_CHECK_EN
    logic         step_err0, step_err1;
`endif

    bin_to_gray_counter #(.N(N), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_gray(ld_gray),
        .bin(bin0), .gray(gray0), .wrap(wrap0), .at_max(at_max0), .at_min(at_min0)
`ifdef GRAY_STEP_CHECK_EN
        , .step_err(step_err0)
`endif
    );

    bin_to_gray_counter #(.N(N), .SATURATE(1'b1)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_gray(ld_gray),
        .bin(bin1), .gray(gray1), .wrap(wrap1), .at_max(at_max1), .at_min(at_min1)
`ifdef GRAY_STEP_CHECK_EN
        , .step_err(step_err1)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int mb[2];
    int mw[2];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Decode by search over the code table rather than a bit recurrence.
    function automatic int g2b(input int g);
        for (int b = 0; b <= MAXV; b++) if ((b ^ (b >> 1)) == g) return b;
        return -1;
    endfunction

    task automatic model_edge();
        for (int s = 0; s < 2; s++) begin
            mw[s] = 0;
            if (ld) begin
                mb[s] = g2b(int'(ld_gray));
            end else if (en) begin
                if (up) begin
                    if (mb[s] == MAXV) begin
                        if (s == 0) begin mb[s] = 0; mw[s] = 1; end
                    end else mb[s] = mb[s] + 1;
                end else begin
                    if (mb[s] == 0) begin
                        if (s == 0) begin mb[s] = MAXV; mw[s] = 1; end
                    end else mb[s] = mb[s] - 1;
                end
            end
        end
    endtask

    task automatic check_model();
        check("bin0",    bin0,    mb[0]);
        check("gray0",   gray0,   mb[0] ^ (mb[0] >> 1));
        check("wrap0",   wrap0,   mw[0]);
        check("at_max0", at_max0, mb[0] == MAXV);
        check("at_min0", at_min0, mb[0] == 0);
        check("bin1",    bin1,    mb[1]);
        check("gray1",   gray1,   mb[1] ^ (mb[1] >> 1));
        check("wrap1",   wrap1,   mw[1]);
        check("at_max1", at_max1, mb[1] == MAXV);
        check("at_min1", at_min1, mb[1] == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mb[0] = 0; mb[1] = 0; mw[0] = 0; mw[1] = 0;
        #1;
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] seq[16];
        logic [N-1:0] pg0;
        int           wraps0, wraps1, old1;
        bit           step;

        seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        rst = 1'b1; en = 1'b0; up = 1'b0; ld = 1'b0; ld_gray = '0;
        mb[0] = 0; mb[1] = 0; mw[0] = 0; mw[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst = 1'b0;

        // Full up sweep with wrap (u0) and saturation (u1).
        en = 1'b1; up = 1'b1; wraps0 = 0; wraps1 = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("seq_gray", gray0, seq[k % 16]);
            wraps0 += int'(wrap0);
            wraps1 += int'(wrap1);
            if (k == 15) check("at_max_top", at_max0, 1);
        end
        check("wrap_count0", wraps0, 1);
        repeat (3) begin
            tick();
            wraps1 += int'(wrap1);
        end
        check("sat_hold_bin", bin1, 15);
        check("sat_hold_gray", gray1, 4'b1000);
        check("wrap_count1", wraps1, 0);
        up = 1'b0;
        tick();
        check("sat_dn_bin", bin1, 14);
        check("sat_dn_gray", gray1, 4'b1001);

        // Down step from zero.
        en = 1'b0;
        do_reset();
        en = 1'b1; up = 1'b0;
        tick();
        check("dn_wrap_bin", bin0, 15);
        check("dn_wrap_gray", gray0, 4'b1000);
        check("dn_wrap_pulse", wrap0, 1);
        en = 1'b0;
        tick();
        check("wrap_one_cycle", wrap0, 0);

        // Load, then load beating a step request.
        ld = 1'b1; ld_gray = 4'b0110;
        tick();
        check("ld_bin", bin0, 4);
        en = 1'b1; up = 1'b1; ld_gray = 4'b1000;
        tick();
        check("ld_wins", bin0, 15);
        ld = 1'b0;

        // Asynchronous reset between edges.
        en = 1'b0;
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (5) tick();
        check("pre_rst_bin", bin0, 5);
        #3;
        rst = 1'b1;
        mb[0] = 0; mb[1] = 0; mw[0] = 0; mw[1] = 0;
        #1;
        check_model();
        check("async_rst_bin", bin0, 0);
        #2;
        rst = 1'b0;
        tick();
        check("post_rst_bin", bin0, 1);

        // Randomised phase with single-bit-step checking.
        for (int c = 0; c < 400; c++) begin
            en      = ($urandom_range(0, 3) != 0);
            up      = $urandom_range(0, 1);
            ld      = ($urandom_range(0, 9) == 0);
            ld_gray = N'($urandom);
            step    = en && !ld;
            pg0     = gray0;
            old1    = mb[1];
            tick();
            if (step) begin
                check("onebit0", $countones(gray0 ^ pg0), 1);
                check("onebit1", $countones(gray1 ^ N'(old1 ^ (old1 >> 1))), (mb[1] == old1) ? 0 : 1);
            end
`ifdef GRAY_STEP_CHECK_EN
            check("step_err0_clean", step_err0, 0);
            check("step_err1_clean", step_err1, 0);
`endif
        end

`ifdef GRAY_STEP_CHECK_EN
        // Corrupt the code after a step so it differs in two bits from its predecessor.
        ld = 1'b0; en = 1'b0;
        do_reset();
        en = 1'b1; up = 1'b1;
        pg0 = gray0;
        tick();
        force u0.gray = pg0 ^ 4'b0011;
        en = 1'b0;
        @(posedge clk);
        #1;
        release u0.gray;
        check("step_err_set", step_err0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("step_err_sticky", step_err0, 1);
        do_reset();
        check("step_err_cleared", step_err0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
